uart_rx: RTL and testbench

Receive-only UART, the receiving end of the team's transmit-only UART link. It synchronizes the asynchronous serial line and detects start bits using 16x oversampling. It deserializes 8N1 frames, LSB first, and buffers received bytes in an 8-entry show-ahead FIFO for the downstream consumer. It flags framing errors and FIFO overrun.

---
 rtl/uart_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Receive-only 8N1 UART with 16x oversampling and a show-ahead byte FIFO.
// Optional 8E1 framing when the macro UART_RX_PARITY_EN is defined.
// Ports:
//   clk, rst       - system clock (rising edge), asynchronous active-high reset
//   rx_i           - asynchronous serial line, idles high
//   rd_en_i        - pop FIFO head (ignored while empty)
//   data_o         - FIFO head byte, valid while fifo_empty_o is 0
//   fifo_empty_o   - FIFO holds no bytes
//   fifo_full_o    - FIFO holds 2**FIFO_POW2 bytes
//   frame_err_o    - one-cycle pulse when the stop bit is sampled low
//   overrun_o      - sticky: a received byte was dropped because the FIFO was full
//   parity_err_o   - one-cycle pulse on parity mismatch (tied 0 without parity)
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 0,        // must be overridden
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_POW2  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       rd_en_i,
    output logic [7:0] data_o,
    output logic       fifo_empty_o,
    output logic       fifo_full_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int unsigned DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned TW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW    = $clog2(OVERSAMPLE);
    localparam int unsigned AW    = FIFO_POW2;
    localparam int unsigned PW    = FIFO_POW2 + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_POW2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    if (DIV < 1) begin : g_div_check
        $error("uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) rounds below 1");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
        $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end

    // Tick generator: one-cycle enable every DIV clocks
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // Two-flop synchronizer, resets to line-idle level
    logic [1:0] sync;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx_i};
    end

    assign rx_s = sync[1];

    // Receive FSM
    logic [2:0]    state, state_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shreg, shreg_n;
    logic          wr_req;
    logic          ferr_n;
    logic          mid;
`ifdef UART_RX_PARITY_EN
    logic          perr_n;
`endif

    assign mid = (scnt == SW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            scnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bidx  <= bidx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        wr_req  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n  = 1'b0;
`endif
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        scnt_n  = '0;
                        state_n = S_START;
                    end
                end
                S_START: begin
                    // Re-check the start bit at its midpoint to reject glitches
                    if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
                        if (rx_s) begin
                            state_n = S_IDLE;
                        end else begin
                            scnt_n  = '0;
                            bidx_n  = '0;
                            state_n = S_DATA;
                        end
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
                S_DATA: begin
                    if (mid) begin
                        scnt_n  = '0;
                        shreg_n = {rx_s, shreg[7:1]};
                        bidx_n  = bidx + 3'd1;
                        if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: data plus parity bit must XOR to 0
                    if (mid) begin
                        scnt_n  = '0;
                        perr_n  = ^{shreg, rx_s};
                        state_n = S_STOP;
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (mid) begin
                        scnt_n = '0;
                        if (rx_s) begin
                            wr_req  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        scnt_n = scnt + SW'(1);
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high
                    if (rx_s) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err_o <= 1'b0;
        else     frame_err_o <= ferr_n;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err_o <= 1'b0;
        else     parity_err_o <= perr_n;
    end
`else
    assign parity_err_o = 1'b0;
`endif

    // Show-ahead FIFO; pointers carry an extra wrap bit
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;
    logic          empty_q, full_q;
    logic          do_rd, do_wr;

    assign do_rd  = rd_en_i && !empty_q;
    // A pop in the same cycle frees the slot for the incoming byte
    assign do_wr  = wr_req && (!full_q || do_rd);
    assign wptr_n = do_wr ? wptr + PW'(1) : wptr;
    assign rptr_n = do_rd ? rptr + PW'(1) : rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            wptr    <= wptr_n;
            rptr    <= rptr_n;
            empty_q <= (wptr_n == rptr_n);
            full_q  <= (wptr_n == {~rptr_n[AW], rptr_n[AW-1:0]});
            if (do_wr)            mem[wptr[AW-1:0]] <= shreg;
            if (wr_req && !do_wr) overrun_o <= 1'b1;
        end
    end

    assign data_o       = mem[rptr[AW-1:0]];
    assign fifo_empty_o = empty_q;
    assign fifo_full_o  = full_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus pushes expected bytes/flags,
// a monitor pops the FIFO and compares against the queue.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 3_686_400;
    localparam int unsigned BAUD     = 115_200;
    localparam int          BIT_CLK  = 32;
    localparam int          DEPTH    = 8;
`ifdef UART_RX_PARITY_EN
    localparam int          FRAME_CLK = 11 * BIT_CLK;
`else
    localparam int          FRAME_CLK = 10 * BIT_CLK;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic [7:0] data;
    logic       empty, full, ferr, ovr, perr;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16),
        .FIFO_POW2 (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .rd_en_i     (rd_en),
        .data_o      (data),
        .fifo_empty_o(empty),
        .fifo_full_o (full),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .parity_err_o(perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard / model state
    logic [7:0] exp_q [$];
    int  n_cmp = 0, n_bad = 0;
    int  ferr_cnt = 0, perr_cnt = 0, exp_ferr = 0, exp_perr = 0;
    logic exp_ovr = 1'b0;
    bit  drain = 1'b0;
    int  pend_pops = 0, pop_cyc = -1;
    bit  seen_write = 1'b0;
    int  first_wr_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts error pulses and pops/compares FIFO bytes
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (ferr) ferr_cnt++;
            if (perr) perr_cnt++;
            if (!rst && !empty) begin
                if (!seen_write) begin
                    seen_write   = 1'b1;
                    first_wr_cyc = cyc;
                end
                if (drain || (pend_pops > 0 && cyc == pop_cyc)) begin
                    if (exp_q.size() == 0) check("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                    else                   check("fifo_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                    if (!drain) pend_pops--;
                    rd_en = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ bad_par);
`endif
        bit_out(stop_bit);
    endtask

    // Model: decide the frame's outcome from the FIFO occupancy it will meet
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic bad_par);
        if (stop_ok) begin
            if (exp_q.size() - pend_pops < DEPTH) exp_q.push_back(b);
            else                                  exp_ovr = 1'b1;
            if (bad_par) exp_perr++;
        end else begin
            exp_ferr++;
        end
        send_frame(b, stop_ok, bad_par);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && empty) break;
        end
        check("drained", {31'd0, (exp_q.size() == 0 && empty)}, 32'd1);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err_pulses"}, ferr_cnt, exp_ferr);
        check({tag, "_parity_err_pulses"}, perr_cnt, exp_perr);
        check({tag, "_overrun"}, {31'd0, ovr}, {31'd0, exp_ovr});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, {31'd0, empty}, 32'd1);
        check({tag, "_full"},  {31'd0, full},  32'd0);
        check({tag, "_data"},  {24'd0, data},  32'd0);
        check({tag, "_ferr"},  {31'd0, ferr},  32'd0);
        check({tag, "_ovr"},   {31'd0, ovr},   32'd0);
        check({tag, "_perr"},  {31'd0, perr},  32'd0);
    endtask

    initial begin
        int s, lat;
        logic [7:0] b;
        logic bp;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        idle(5);

        // Single byte 0xA5, latency from start edge to FIFO write
        seen_write = 1'b0;
        @(negedge clk);
        s = cyc;
        @(posedge clk);
        send_byte(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check("a5_empty", {31'd0, empty}, 32'd0);
        check("a5_data", {24'd0, data}, 32'hA5);
        lat = first_wr_cyc - s;
        check("a5_write_latency_window", {31'd0, (lat >= 306 && lat <= 310)}, 32'd1);
        check_flags("a5");
        drain = 1'b1;
        wait_drained();

        // Short low glitch is rejected; a following byte still arrives
        @(posedge clk);
        rx = 1'b0;
        repeat (12) @(posedge clk);
        idle(3 * BIT_CLK);
        @(negedge clk);
        check("glitch_empty", {31'd0, empty}, 32'd1);
        check_flags("glitch");
        @(posedge clk);
        send_byte(8'($urandom), 1'b1, 1'b0);
        wait_drained();

        // Framing error, long break, then a valid byte
        @(posedge clk);
        send_byte(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT_CLK) @(posedge clk);
        idle(BIT_CLK);
        send_byte(8'h55, 1'b1, 1'b0);
        wait_drained();
        check_flags("ferr");

        // Randomised bytes with random idle gaps
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom);
            bp = 1'b0;
`ifdef UART_RX_PARITY_EN
            bp = ($urandom_range(0, 3) == 0);
`endif
            idle($urandom_range(1, 40));
            send_byte(b, 1'b1, bp);
        end
        wait_drained();
        check_flags("random");

        // Ten back-to-back bytes with no reads: full after 8, overrun on the 9th
        drain = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
            if (i >= 6 && i <= 8) begin
                check($sformatf("fill%0d_full", i), {31'd0, full}, {31'd0, (exp_q.size() == DEPTH)});
                check($sformatf("fill%0d_ovr", i), {31'd0, ovr}, {31'd0, exp_ovr});
            end
        end
        drain = 1'b1;
        wait_drained();
        check("fill_full_after_drain", {31'd0, full}, 32'd0);
        check_flags("fill");

        // Reset in the middle of data bit 4
        drain = 1'b0;
        @(posedge clk);
        send_byte(8'h77, 1'b1, 1'b0);
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (5 * BIT_CLK + 16) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                exp_q.delete();
                exp_ovr = 1'b0;
                @(negedge clk);
                check_reset("midrst");
                rst = 1'b0;
            end
        join
        idle(2 * FRAME_CLK);
        @(negedge clk);
        check("midrst_no_write", {31'd0, empty}, 32'd1);
        check_flags("midrst");

        // Full FIFO: pop in the very cycle the next byte is written
        seen_write = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        pop_cyc   = first_wr_cyc + 8 * FRAME_CLK - 1;
        pend_pops = 1;
        send_byte(8'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        check("simul_pop_done", pend_pops, 32'd0);
        check("simul_full", {31'd0, full}, {31'd0, (exp_q.size() == DEPTH)});
        check_flags("simul");
        drain = 1'b1;
        wait_drained();

`ifdef UART_RX_PARITY_EN
        // 0x01 with parity bit 0 (wrong for even parity)
        @(posedge clk);
        send_byte(8'h01, 1'b1, 1'b1);
        wait_drained();
        check_flags("parity");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
